// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state encodings and counter sizing for the bit-serial arithmetic blocks
package serial_arith_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/full_half_sub_1bit.sv
// full_half_sub_1bit: combinational full subtractor built from two chained half subtractors
module full_half_sub_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_borrow
);
  logic d1, b1, b2;
  assign d1       = i_a ^ i_b;
  assign b1       = ~i_a & i_b;
  assign o_diff   = d1 ^ i_bin;
  assign b2       = ~d1 & i_bin;
  assign o_borrow = b1 | b2;
endmodule

// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit: bit-serial WIDTH-bit subtractor, LSB first through one full subtractor, valid/ready on both sides
module serial_sub_nbit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_busy
);
  localparam int CW = cnt_w(WIDTH);
  logic [1:0] state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic br, d, bo, accept, last;
  logic [CW-1:0] cnt;
  assign accept = (state == S_IDLE) && i_valid;
  assign last   = cnt == CW'(WIDTH - 1);
  full_half_sub_1bit u_fs (
    .i_a     (a_sr[0]),
    .i_b     (b_sr[0]),
    .i_bin   (br),
    .o_diff  (d),
    .o_borrow(bo)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end
  always_comb begin
    state_n = (state == S_IDLE)  ? (i_valid ? S_SHIFT : S_IDLE) :
              (state == S_SHIFT) ? (last ? S_DONE : S_SHIFT) :
              (state == S_DONE)  ? (i_ready ? S_IDLE : S_DONE) : S_IDLE;
  end
  always_comb begin
    o_ready  = state == S_IDLE;
    o_valid  = state == S_DONE;
    o_busy   = state == S_SHIFT;
    o_diff   = d_sr;
    o_borrow = br;
  end
  // each difference bit enters at the MSB so after WIDTH shifts bit 0 sits at d_sr[0]
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= i_a;
      b_sr <= i_b;
      d_sr <= '0;
      br   <= i_bin;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= (d_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
      br   <= bo;
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_sub_nbit.sv
// tb_serial_sub_nbit: directed and randomized checks of serial_sub_nbit at WIDTH=8 and WIDTH=1
module tb_serial_sub_nbit;
  logic clk = 1'b0, rst = 1'b1;
  logic valid = 1'b0, rdy = 1'b0, bin_in = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic o_ready, o_valid, o_borrow, o_busy;
  logic [7:0] o_diff;
  logic v1 = 1'b0, r1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic o_ready1, o_valid1, o_borrow1, o_busy1;
  logic [0:0] o_diff1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  serial_sub_nbit #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_a(a_in), .i_b(b_in), .i_bin(bin_in), .o_valid(o_valid),
    .i_ready(rdy), .o_diff(o_diff), .o_borrow(o_borrow), .o_busy(o_busy)
  );
  serial_sub_nbit #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(o_ready1),
    .i_a(a1), .i_b(b1), .i_bin(bin1), .o_valid(o_valid1),
    .i_ready(r1), .o_diff(o_diff1), .o_borrow(o_borrow1), .o_busy(o_busy1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bin, input int stall, input bit early);
    logic [8:0] e;
    int n;
    e = {1'b0, a} - {1'b0, b} - 9'(bin);
    n = 0;
    while (!o_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_accept", o_ready, 1);
    valid = 1'b1; a_in = a; b_in = b; bin_in = bin; rdy = early;
    @(negedge clk);
    valid = 1'b0;
    chk("busy_in_shift", o_busy, 1);
    chk("ready_low_in_shift", o_ready, 0);
    n = 0;
    while (!o_valid && n < 50) begin @(negedge clk); n++; end
    chk("latency", n, 8);
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        chk("stall_diff", o_diff, e[7:0]);
        chk("stall_borrow", o_borrow, e[8]);
        chk("stall_ready_low", o_ready, 0);
        @(negedge clk);
      end
      rdy = 1'b1;
    end
    chk("valid_done", o_valid, 1);
    chk("diff", o_diff, e[7:0]);
    chk("borrow", o_borrow, e[8]);
    @(negedge clk);
    rdy = 1'b0;
    chk("valid_after_pop", o_valid, 0);
    chk("ready_after_pop", o_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_diff", o_diff, 0);
    chk("rst_borrow", o_borrow, 0);
    chk("rst_busy", o_busy, 0);
    rst = 1'b0;
    op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    op(8'h00, 8'h01, 1'b0, 0, 1'b0);
    op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    op(8'h00, 8'h00, 1'b1, 0, 1'b0);
    op(8'h80, 8'h7F, 1'b0, 5, 1'b0);
    op(8'h12, 8'h34, 1'b1, 0, 1'b1);
    // i_valid with new operands during SHIFT must not disturb the running op
    valid = 1'b1; a_in = 8'h9C; b_in = 8'h1D; bin_in = 1'b0;
    @(negedge clk);
    a_in = 8'h00; b_in = 8'hFF; bin_in = 1'b1;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignore_valid_done", o_valid, 1);
    chk("ignore_valid_diff", o_diff, 8'h7F);
    chk("ignore_valid_borrow", o_borrow, 0);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("ignore_valid_idle", o_ready, 1);
    // reset during the 4th SHIFT cycle
    valid = 1'b1; a_in = 8'h33; b_in = 8'h44; bin_in = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_diff", o_diff, 0);
    chk("midrst_busy", o_busy, 0);
    op(8'hC3, 8'h5A, 1'b1, 2, 1'b0);
    // WIDTH=1 instance
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1; bin1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("w1_busy", o_busy1, 1);
    chk("w1_not_valid_yet", o_valid1, 0);
    @(negedge clk);
    chk("w1_valid", o_valid1, 1);
    chk("w1_diff", o_diff1, 0);
    chk("w1_borrow", o_borrow1, 1);
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;
    chk("w1_ready_after_pop", o_ready1, 1);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    chk("w1b_valid", o_valid1, 1);
    chk("w1b_diff", o_diff1, 1);
    chk("w1b_borrow", o_borrow1, 0);
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;
    for (int k = 0; k < 100; k++)
      op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
